// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared constants for the multicycle MIPS control unit: FSM state codes,
// opcode and funct encodings, ALU control codes and the internal alu_op
// selector that the main FSM hands to the ALU decoder.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

   localparam int OPW   = 6;
   localparam int FNW   = 6;
   localparam int ALUCW = 4;

   typedef logic [3:0] state_t;

   // FSM state codes (also visible on state_o)
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   // ALU control codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // alu_op: what the FSM asks of the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode.
//   alu_op        in  2   00=ADD, 01=SUB, 10=decode funct
//   funct         in  FNW instr[5:0]
//   alu_control   out ALUCW  ALU operation code
//   illegal_funct out 1   funct is not a supported R-type operation
//                         (only meaningful when alu_op=10)
// ---------------------------------------------------------------------------
module alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int FNW   = mips_ctrl_pkg::FNW,
   parameter int ALUCW = mips_ctrl_pkg::ALUCW
) (
   input  logic [1:0]       alu_op,
   input  logic [FNW-1:0]   funct,
   output logic [ALUCW-1:0] alu_control,
   output logic             illegal_funct
);

   always_comb begin
      alu_control   = ALU_ADD;
      illegal_funct = 1'b0;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               F_ADD:   alu_control = ALU_ADD;
               F_SUB:   alu_control = ALU_SUB;
               F_AND:   alu_control = ALU_AND;
               F_OR:    alu_control = ALU_OR;
               F_SLT:   alu_control = ALU_SLT;
               default: begin
                  // unsupported funct: keep the harmless ADD code
                  alu_control   = ALU_ADD;
                  illegal_funct = 1'b1;
               end
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore FSM sequencing the multicycle MIPS datapath (PC, memory, IR,
// register file, shared ALU) through fetch/decode/execute/memory/writeback.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   opcode, funct       instruction fields from the instruction register
//   zero                ALU zero flag (same cycle, used for beq)
//   pc_en               PC load = pc_write | (branch & zero)
//   iord                memory address select 0=PC, 1=ALUOut
//   mem_write, ir_write memory write strobe, instruction register load
//   reg_dst, mem_to_reg register write destination / data selects
//   reg_write           register file write
//   alu_src_a/_b        ALU operand selects
//   pc_src              next-PC select 00=ALU, 01=ALUOut, 10=jump target
//   alu_control         ALU operation code
//   illegal_op          one-cycle pulse on unsupported opcode or funct
//   state_o             current state for debug
// ---------------------------------------------------------------------------
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OPW   = mips_ctrl_pkg::OPW,
   parameter int FNW   = mips_ctrl_pkg::FNW,
   parameter int ALUCW = mips_ctrl_pkg::ALUCW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OPW-1:0]   opcode,
   input  logic [FNW-1:0]   funct,
   input  logic             zero,
   output logic             pc_en,
   output logic             iord,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_src,
   output logic [ALUCW-1:0] alu_control,
   output logic             illegal_op,
   output logic [3:0]       state_o
);

   state_t     state_reg;
   state_t     state_next;
   logic       pc_write;
   logic       branch;
   logic [1:0] alu_op;
   logic       illegal_funct;

   alu_decoder #(
      .FNW   (FNW),
      .ALUCW (ALUCW)
   ) u_alu_decoder (
      .alu_op        (alu_op),
      .funct         (funct),
      .alu_control   (alu_control),
      .illegal_funct (illegal_funct)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Output decode and next-state logic. Every state that is not listed
   // (including the unused codes 13-15) falls back to all-zero outputs,
   // ADD on the ALU, and a return to FETCH.
   always_comb begin
      state_next = S_FETCH;
      pc_write   = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_op     = ALUOP_ADD;
      illegal_op = 1'b0;
      case (state_reg)
         S_IDLE: state_next = S_FETCH;
         S_FETCH: begin
            alu_src_b  = 2'b01;
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            // precompute branch target into ALUOut
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE:     state_next = S_EXEC;
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            // only lw/sw reach this state, so anything not lw is sw
            state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord       = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
            if (illegal_funct) begin
               // abandon the instruction before any writeback
               illegal_op = 1'b1;
               state_next = S_FETCH;
            end else begin
               state_next = S_ALUWB;
            end
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = 2'b01;
            branch    = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = S_ADDIWB;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

   assign pc_en   = pc_write | (branch & zero);
   assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Table of instructions, each with its expected state walk; per-cycle
// expected output words are queued when the instruction is applied and
// popped against the DUT on every falling edge. Hand-written sequences
// cover reset and a reset pulse in the middle of a load.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_en;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [3:0] alu_control;
      logic       illegal_op;
   } outv_t;

   typedef struct packed {
      logic [5:0]      opcode;
      logic [5:0]      funct;
      logic            zero;
      logic [2:0]      n;
      logic [4:0][3:0] seq;
      logic [3:0]      exec_alu;
      logic            ill;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg;
   logic       reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, pc_src;
   logic [3:0] alu_control, state_o;

   outv_t act;
   outv_t exp_q[$];
   vec_t  vecs[14];
   int    checks   = 0;
   int    failures = 0;

   multicycle_control dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .pc_en       (pc_en),
      .iord        (iord),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .pc_src      (pc_src),
      .alu_control (alu_control),
      .illegal_op  (illegal_op),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   assign act = {state_o, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, pc_src, alu_control, illegal_op};

   // Expected outputs of each state, written out from the control table.
   function automatic outv_t base(input logic [3:0] st);
      outv_t o;
      o = '0;
      o.st = st;
      o.alu_control = 4'b0010;
      case (st)
         4'd1: begin o.pc_en = 1; o.ir_write = 1; o.alu_src_b = 2'b01; end
         4'd2: o.alu_src_b = 2'b11;
         4'd3: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         4'd4: o.iord = 1;
         4'd5: begin o.mem_to_reg = 1; o.reg_write = 1; end
         4'd6: begin o.iord = 1; o.mem_write = 1; end
         4'd7: o.alu_src_a = 1;
         4'd8: begin o.reg_dst = 1; o.reg_write = 1; end
         4'd9: begin o.alu_src_a = 1; o.alu_control = 4'b0110; o.pc_src = 2'b01; end
         4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         4'd11: o.reg_write = 1;
         4'd12: begin o.pc_src = 2'b10; o.pc_en = 1; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic [2:0] n,
                                input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [3:0] s3,
                                input logic [3:0] s4, input logic [3:0] alu,
                                input logic ill);
      vec_t v;
      v.opcode = op; v.funct = fn; v.zero = z; v.n = n;
      v.seq = {s4, s3, s2, s1, s0};
      v.exec_alu = alu; v.ill = ill;
      return v;
   endfunction

   task automatic chk(input string name, input outv_t e);
      checks++;
      if (act !== e) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (state %0d vs %0d)",
                  name, act, e, act.st, e.st);
      end
   endtask

   // Called on a falling edge while the DUT is in FETCH; returns on the
   // falling edge of the following FETCH.
   task automatic run_vec(input int i);
      vec_t  v;
      outv_t e;
      v = vecs[i];
      opcode = v.opcode;
      funct  = v.funct;
      zero   = v.zero;
      for (int c = 0; c < int'(v.n); c++) begin
         e = base(v.seq[c]);
         if (v.seq[c] == 4'd7) e.alu_control = v.exec_alu;
         if (v.seq[c] == 4'd9) e.pc_en = v.zero;
         if (v.ill && c == int'(v.n) - 1) e.illegal_op = 1'b1;
         exp_q.push_back(e);
      end
      for (int c = 0; c < int'(v.n); c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         chk($sformatf("vec%0d_cyc%0d", i, c), e);
      end
      @(negedge clk);
      $display("vec %0d opcode=%b funct=%b zero=%0d cycles=%0d",
               i, v.opcode, v.funct, v.zero, v.n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //               opcode     funct      z  n  s0 s1 s2 s3 s4 exec_alu ill
      vecs[0]  = mkv(6'b100011, 6'b101010, 1, 5, 1, 2, 3, 4, 5, 4'b0010, 0); // lw
      vecs[1]  = mkv(6'b101011, 6'b000000, 1, 4, 1, 2, 3, 6, 0, 4'b0010, 0); // sw
      vecs[2]  = mkv(6'b000000, 6'b100000, 0, 4, 1, 2, 7, 8, 0, 4'b0010, 0); // add
      vecs[3]  = mkv(6'b000000, 6'b100010, 1, 4, 1, 2, 7, 8, 0, 4'b0110, 0); // sub
      vecs[4]  = mkv(6'b000000, 6'b100100, 0, 4, 1, 2, 7, 8, 0, 4'b0000, 0); // and
      vecs[5]  = mkv(6'b000000, 6'b100101, 0, 4, 1, 2, 7, 8, 0, 4'b0001, 0); // or
      vecs[6]  = mkv(6'b000000, 6'b101010, 0, 4, 1, 2, 7, 8, 0, 4'b0111, 0); // slt
      vecs[7]  = mkv(6'b000100, 6'b000000, 1, 3, 1, 2, 9, 0, 0, 4'b0010, 0); // beq taken
      vecs[8]  = mkv(6'b000100, 6'b000000, 0, 3, 1, 2, 9, 0, 0, 4'b0010, 0); // beq not taken
      vecs[9]  = mkv(6'b001000, 6'b100010, 1, 4, 1, 2, 10, 11, 0, 4'b0010, 0); // addi
      vecs[10] = mkv(6'b000010, 6'b000000, 0, 3, 1, 2, 12, 0, 0, 4'b0010, 0); // j
      vecs[11] = mkv(6'b111111, 6'b100000, 1, 2, 1, 2, 0, 0, 0, 4'b0010, 1); // bad opcode
      vecs[12] = mkv(6'b000000, 6'b100110, 1, 3, 1, 2, 7, 0, 0, 4'b0010, 1); // bad funct
      vecs[13] = mkv(6'b000101, 6'b000000, 1, 2, 1, 2, 0, 0, 0, 4'b0010, 1); // bne unsupported

      reset  = 1'b1;
      opcode = 6'b0;
      funct  = 6'b0;
      zero   = 1'b1;

      @(negedge clk);
      chk("reset_idle", base(4'd0));
      reset = 1'b0;
      #1 chk("release_idle", base(4'd0));
      @(negedge clk);

      for (int i = 0; i < 14; i++) run_vec(i);

      // reset pulse in the middle of a load
      opcode = 6'b100011;
      funct  = 6'b0;
      zero   = 1'b0;
      chk("lwrst_fetch", base(4'd1));
      @(negedge clk); chk("lwrst_decode", base(4'd2));
      @(negedge clk); chk("lwrst_memadr", base(4'd3));
      @(negedge clk); chk("lwrst_memrd", base(4'd4));
      #2 reset = 1'b1;
      #1 chk("rst_async", base(4'd0));
      @(negedge clk); chk("rst_hold", base(4'd0));
      reset = 1'b0;
      #1 chk("rst_released", base(4'd0));
      @(negedge clk); chk("rst_fetch", base(4'd1));
      $display("reset pulse during MEMRD handled");

      run_vec(10);
      run_vec(0);
      chk("final_fetch", base(4'd1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
